// File: rtl/apb_img_writer.sv
// Packs an 8-bit pixel stream into 32-bit words and writes one frame of
// NUM_WORDS words to consecutive APB addresses starting at BASE_ADDR.
module apb_img_writer #(
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int unsigned NUM_WORDS = 196
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [11:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [2:0] {IDLE, PACK, SETUP, ACCESS, DONE} state_t;

  localparam logic [9:0] LAST_WORD = 10'(NUM_WORDS - 1);

  state_t     state;
  logic [9:0] word_cnt;
  logic [1:0] idx;

  // Every output is a flop, loaded on the transition into the state that owns it.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state    <= IDLE;
      word_cnt <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      s_ready  <= 1'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= PACK;
            word_cnt <= '0;
            idx      <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            s_ready  <= 1'b1;
          end
        end
        PACK: begin
          if (s_valid) begin
            PWDATA[{idx, 3'b000} +: 8] <= s_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state   <= SETUP;
              s_ready <= 1'b0;
              PSEL    <= 1'b1;
              PWRITE  <= 1'b1;
              PADDR   <= BASE_ADDR + {word_cnt, 2'b00};
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY) begin
            if (PSLVERR) error <= 1'b1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            if (word_cnt == LAST_WORD) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 10'd1;
              state    <= PACK;
              s_ready  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          s_ready <= 1'b0;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          PWRITE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_img_writer.sv
// Scoreboard bench for apb_img_writer: frame model queues expected APB writes,
// a negedge monitor pops and compares them as the DUT completes transfers.
module tb_apb_img_writer;

  localparam int unsigned NW   = 3;
  localparam logic [11:0] BASE = 12'hFF8;

  logic        PCLK, PRESETN, start, busy, done, error;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;

  apb_img_writer #(.BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .start(start), .busy(busy), .done(done),
    .error(error), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  int          lat_exp = -1;
  int          done_cnt = 0;
  int          acc_total = 0, acc_base = 0;
  int          err_total = 0, err_base = 0;
  int          wmode = 0, emode = 0, gmode = 0;
  int          wl = 0;
  bit          poke_en = 1'b0;
  logic [11:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [7:0]  fbytes [4*NW];
  logic [11:0] cap_a;
  logic [31:0] cap_d;
  logic        prev_psel = 1'b0, prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // APB responder: wait states and error responses chosen per transfer.
  initial begin
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && !PENABLE) begin
        if (wmode == 1)      wl = (acc_total == acc_base) ? 3 : 0;
        else if (wmode == 2) wl = int'($urandom_range(0, 3));
        else if (wmode == 3) wl = 5;
        else                 wl = 0;
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
      end else if (PSEL && PENABLE) begin
        if (wl == 0) begin
          PREADY  = 1'b1;
          PSLVERR = (emode == 1 && acc_total == acc_base) ||
                    (emode == 2 && $urandom_range(0, 2) == 0);
          if (PSLVERR) err_total++;
          acc_total++;
        end else begin
          wl--;
          PREADY  = 1'b0;
          PSLVERR = 1'($urandom);
        end
      end else begin
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge PCLK);
    if (!PRESETN) begin
      addr_q.delete();
      data_q.delete();
      prev_psel = 1'b0;
      prev_done = 1'b0;
      continue;
    end
    if (PSEL) begin
      chk("pwrite_high", 32'(PWRITE), 32'd1);
      chk("s_ready_low_in_apb", 32'(s_ready), 32'd0);
    end
    if (PSEL && !PENABLE) begin
      cap_a = PADDR;
      cap_d = PWDATA;
    end
    if (PSEL && PENABLE) begin
      chk("setup_before_access", 32'(prev_psel), 32'd1);
      chk("paddr_stable", 32'(PADDR), 32'(cap_a));
      chk("pwdata_stable", PWDATA, cap_d);
      if (PREADY) begin
        chk("write_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) begin
          chk("paddr", 32'(PADDR), 32'(addr_q.pop_front()));
          chk("pwdata", PWDATA, data_q.pop_front());
        end
      end
    end
    if (!busy) chk("idle_outputs", 32'({PSEL, PENABLE, s_ready, done}), 32'd0);
    if (done) begin
      done_cnt++;
      chk("done_one_cycle", 32'(prev_done), 32'd0);
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("error_at_done", 32'(error), 32'(err_total != err_base));
      chk("writes_left_at_done", 32'(addr_q.size()), 32'd0);
      if (lat_exp >= 0) chk("done_latency", 32'(cyc - t0), 32'(lat_exp));
    end
    prev_psel = PSEL;
    prev_done = done;
  end

  task automatic start_frame(input int lat);
    for (int k = 0; k < int'(NW); k++) begin
      addr_q.push_back(12'(32'(BASE) + 32'(4 * k)));
      data_q.push_back({fbytes[4*k+3], fbytes[4*k+2], fbytes[4*k+1], fbytes[4*k]});
    end
    acc_base = acc_total;
    err_base = err_total;
    lat_exp  = lat;
    start = 1'b1;
    @(posedge PCLK);
    #1;
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("error_cleared_by_start", 32'(error), 32'd0);
    chk("s_ready_in_pack", 32'(s_ready), 32'd1);
  endtask

  task automatic feed(input int nbytes);
    int   i = 0, guard = 0, gaps = 0;
    logic acc;
    while (i < nbytes && guard < 500) begin
      if ((gmode == 1 && i == 2 && gaps < 2) || (gmode == 2 && $urandom_range(0, 3) == 0)) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        gaps++;
      end else begin
        s_valid = 1'b1;
        s_data  = fbytes[i];
      end
      start = poke_en && busy && ($urandom_range(0, 5) == 0);
      @(negedge PCLK);
      acc = s_valid && s_ready;
      @(posedge PCLK);
      #1;
      if (acc) i++;
      guard++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("bytes_accepted", 32'(i), 32'(nbytes));
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (done_cnt < target && g < 2000) begin
      start = poke_en && busy && (done || $urandom_range(0, 5) == 0);
      @(posedge PCLK);
      #2;
      g++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cnt), 32'(target));
    chk("idle_after_done", 32'({busy, s_ready, PSEL}), 32'd0);
    chk("error_sticky", 32'(error), 32'(err_total != err_base));
  endtask

  task automatic run_frame(input int lat);
    int target;
    target = done_cnt + 1;
    start_frame(lat);
    feed(4 * int'(NW));
    wait_done(target);
  endtask

  initial begin
    int g, dc;
    PRESETN = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge PCLK);
    chk("reset_flags", 32'({PSEL, PENABLE, PWRITE, s_ready, busy, done, error}), 32'd0);
    chk("reset_paddr", 32'(PADDR), 32'd0);
    chk("reset_pwdata", PWDATA, 32'd0);
    PRESETN = 1'b1;
    @(posedge PCLK);
    #1;

    for (int i = 0; i < 4 * int'(NW); i++) fbytes[i] = 8'(i + 1);
    run_frame(6 * int'(NW));
    wmode = 1;
    run_frame(6 * int'(NW) + 3);
    wmode = 0;
    gmode = 1;
    run_frame(6 * int'(NW) + 2);
    gmode = 0;
    emode = 1;
    run_frame(6 * int'(NW));
    emode = 0;
    for (int i = 0; i < 4 * int'(NW); i++) fbytes[i] = 8'(8'hFD + i);
    run_frame(6 * int'(NW));

    poke_en = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4 * int'(NW); i++) fbytes[i] = 8'($urandom);
      wmode = 2;
      gmode = 2;
      emode = int'($urandom_range(0, 2));
      run_frame(-1);
    end
    poke_en = 1'b0;
    wmode = 3;
    gmode = 0;
    emode = 0;

    // Reset pulse while the second word's ACCESS is stalled.
    dc = done_cnt;
    start_frame(-1);
    feed(8);
    g = 0;
    do begin
      @(negedge PCLK);
      g++;
    end while (!(PSEL && PENABLE) && g < 50);
    chk("reset_point_paddr", 32'(PADDR), 32'(12'(32'(BASE) + 32'd4)));
    PRESETN = 1'b0;
    #1;
    chk("reset_mid_access_flags", 32'({PSEL, PENABLE, s_ready, busy, done, error}), 32'd0);
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    repeat (5) @(negedge PCLK);
    chk("idle_after_reset", 32'(busy), 32'd0);
    chk("no_done_after_reset", 32'(done_cnt), 32'(dc));
    wmode = 0;
    @(posedge PCLK);
    #1;
    for (int i = 0; i < 4 * int'(NW); i++) fbytes[i] = 8'($urandom);
    run_frame(6 * int'(NW));

    repeat (3) @(posedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
